// File: rtl/factor_game_pkg.sv
// Shared constants for the factorisation quiz sequencer: state encodings,
// result codes and the fixed problem table.
package factor_game_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_GEN   = 3'd1;
   localparam state_t ST_INPUT = 3'd2;
   localparam state_t ST_MUL1  = 3'd3;
   localparam state_t ST_MUL2  = 3'd4;
   localparam state_t ST_SHOW  = 3'd5;
   localparam state_t ST_OVER  = 3'd6;

   localparam logic [1:0] RES_NONE  = 2'b00;
   localparam logic [1:0] RES_WRONG = 2'b01;
   localparam logic [1:0] RES_RIGHT = 2'b11;

   // Every entry factors into three digits 1..9.
   localparam logic [9:0] PROBLEM_TABLE [16] = '{
      10'd8,   10'd12,  10'd18,  10'd24,  10'd30,  10'd36,  10'd42,  10'd48,
      10'd60,  10'd72,  10'd84,  10'd96,  10'd120, 10'd144, 10'd210, 10'd504
   };

   function automatic logic digit_valid(input logic [3:0] d);
      return (d >= 4'd1) && (d <= 4'd9);
   endfunction

endpackage

// File: rtl/factor_game_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4) used to pick problems.
module factor_game_lfsr #(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       CLK,
   input  logic       RST,
   output logic [7:0] lfsr_q
);

   // Shift left, feedback from taps 8,6,5,4 into bit 0.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) lfsr_q <= SEED;
      else      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   end

endmodule

// File: rtl/factor_game_ctrl.sv
// Factorisation quiz sequencer: picks a target, checks the product of three
// submitted digits against it, and tracks score and remaining tries.
// Optional answer time limit enabled by macro FACTOR_GAME_TIMEOUT_EN.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for START_IN after reset
// GEN      | one cycle: choose next problem from the table
// INPUT    | waiting for DEC_IN (or time limit expiry)
// MUL1     | first partial product d1*d2
// MUL2     | full product, verdict registered
// SHOW     | verdict held for HOLD_CYCLES
// OVER     | tries exhausted, waiting for START_IN
module factor_game_ctrl
   import factor_game_pkg::*;
#(
   parameter int         HOLD_CYCLES = 50_000_000,
   parameter int         MAX_TRIES   = 3,
   parameter logic [7:0] LFSR_SEED   = 8'hA5
`ifdef FACTOR_GAME_TIMEOUT_EN
   ,
   parameter int         TIME_LIMIT  = 500_000_000
`endif
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START_IN,
   input  logic       DEC_IN,
   input  logic [3:0] DIG1_IN,
   input  logic [3:0] DIG2_IN,
   input  logic [3:0] DIG3_IN,
   output logic [1:0] RESULT_OUT,
   output logic [9:0] TARGET_OUT,
   output logic [7:0] SCORE_OUT,
   output logic [1:0] TRIES_OUT,
   output logic       BUSY_OUT
`ifdef FACTOR_GAME_TIMEOUT_EN
   ,
   output logic       TIMEOUT_OUT
`endif
);

   state_t     state;
   logic [7:0] lfsr_q;
   logic [3:0] prev_idx;
   logic [3:0] gen_idx;
   logic [3:0] d1, d2, d3;
   logic [6:0] part_prod;
   logic [9:0] full_prod;
   logic       answer_ok;
   logic [31:0] hold_cnt;

   factor_game_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .CLK    (CLK),
      .RST    (RST),
      .lfsr_q (lfsr_q)
   );

   // Problem index: avoid repeating the previous problem back to back.
   // Verdict: any digit outside 1..9 is wrong whatever the product says.
   always_comb begin
      gen_idx = lfsr_q[3:0];
      if (gen_idx == prev_idx) gen_idx = gen_idx + 4'd1;
      full_prod = {3'b000, part_prod} * {6'b000000, d3};
      answer_ok = digit_valid(d1) && digit_valid(d2) && digit_valid(d3) &&
                  (full_prod == TARGET_OUT);
   end

   assign BUSY_OUT = (state == ST_MUL1) || (state == ST_MUL2) || (state == ST_SHOW);

`ifdef FACTOR_GAME_TIMEOUT_EN
   logic [31:0] lim_cnt;

   // Answer time limit: reloaded whenever outside INPUT, counts down inside it.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)                  lim_cnt <= 32'(TIME_LIMIT - 1);
      else if (state != ST_INPUT) lim_cnt <= 32'(TIME_LIMIT - 1);
      else if (lim_cnt != '0)    lim_cnt <= lim_cnt - 32'd1;
   end
`endif

   // Main sequencing FSM with score, tries and result registers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state      <= ST_IDLE;
         prev_idx   <= 4'hF;
         d1         <= '0;
         d2         <= '0;
         d3         <= '0;
         part_prod  <= '0;
         hold_cnt   <= '0;
         RESULT_OUT <= RES_NONE;
         TARGET_OUT <= '0;
         SCORE_OUT  <= '0;
         TRIES_OUT  <= '0;
`ifdef FACTOR_GAME_TIMEOUT_EN
         TIMEOUT_OUT <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE, ST_OVER: begin
               if (START_IN) begin
                  state      <= ST_GEN;
                  SCORE_OUT  <= '0;
                  TRIES_OUT  <= 2'(MAX_TRIES);
                  RESULT_OUT <= RES_NONE;
               end
            end
            ST_GEN: begin
               TARGET_OUT <= PROBLEM_TABLE[gen_idx];
               prev_idx   <= gen_idx;
               state      <= ST_INPUT;
            end
            ST_INPUT: begin
               if (DEC_IN) begin
                  d1    <= DIG1_IN;
                  d2    <= DIG2_IN;
                  d3    <= DIG3_IN;
                  state <= ST_MUL1;
`ifdef FACTOR_GAME_TIMEOUT_EN
               end else if (lim_cnt == '0) begin
                  RESULT_OUT  <= RES_WRONG;
                  TRIES_OUT   <= TRIES_OUT - 2'd1;
                  TIMEOUT_OUT <= 1'b1;
                  hold_cnt    <= 32'(HOLD_CYCLES - 1);
                  state       <= ST_SHOW;
`endif
               end
            end
            ST_MUL1: begin
               part_prod <= {3'b000, d1} * {3'b000, d2};
               state     <= ST_MUL2;
            end
            ST_MUL2: begin
               if (answer_ok) begin
                  RESULT_OUT <= RES_RIGHT;
                  TRIES_OUT  <= 2'(MAX_TRIES);
                  if (SCORE_OUT != 8'hFF) SCORE_OUT <= SCORE_OUT + 8'd1;
               end else begin
                  RESULT_OUT <= RES_WRONG;
                  TRIES_OUT  <= TRIES_OUT - 2'd1;
               end
               hold_cnt <= 32'(HOLD_CYCLES - 1);
               state    <= ST_SHOW;
            end
            ST_SHOW: begin
               if (hold_cnt == '0) begin
`ifdef FACTOR_GAME_TIMEOUT_EN
                  TIMEOUT_OUT <= 1'b0;
`endif
                  if (RESULT_OUT == RES_RIGHT) begin
                     RESULT_OUT <= RES_NONE;
                     state      <= ST_GEN;
                  end else if (TRIES_OUT != 2'd0) begin
                     RESULT_OUT <= RES_NONE;
                     state      <= ST_INPUT;
                  end else begin
                     state <= ST_OVER;
                  end
               end else begin
                  hold_cnt <= hold_cnt - 32'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
